fft_control_n: RTL and testbench

Parametrised radix-2 DIT FFT sequencer for N = 2^LOG2N points and a configurable butterfly-pipeline latency. It drives the sample memory load, the single-issue butterfly datapath and the result read-out with a ready/valid handshake. Each stage issues exactly N/2 butterflies, with no redundant re-issue. The block generates butterfly operand addresses and twiddle addresses internally. It supports bit-reversed load addressing, output backpressure and synchronous abort.

---
 rtl/fft_control_n.sv | 191 +++++++++++++++++++
 tb/tb_fft_control_n.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_control_n.sv
// fft_control_n: radix-2 DIT FFT sequencer that drives the sample load, single-issue butterfly
// datapath and result read-out. Butterfly and twiddle addresses are decoded from registered counters.
module fft_control_n #(
  parameter int LOG2N       = 3,
  parameter int LAT         = 6,
  parameter int BITREV_LOAD = 1,
  localparam int N  = 2 ** LOG2N,
  localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1,
  localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1,
  localparam int LW = (LAT > 1) ? $clog2(LAT) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_valid_in,
  output logic             o_ready_in,
  output logic             o_load_en,
  output logic [LOG2N-1:0] o_load_addr,
  output logic             o_issue,
  output logic [SW-1:0]    o_stage_sel,
  output logic [KW-1:0]    o_k_idx,
  output logic [LOG2N-1:0] o_addr_a,
  output logic [LOG2N-1:0] o_addr_b,
  output logic [KW-1:0]    o_twiddle_addr,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [LOG2N-1:0] o_out_addr,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    OUTPUT
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [LOG2N-1:0] r_loadCnt;
  logic [SW-1:0]    r_stage;
  logic [KW-1:0]    r_k;
  logic [LW-1:0]    r_latCnt;
  logic [LOG2N-1:0] r_outCnt;
  logic             r_done;

  logic             w_loadLast;
  logic             w_kLast;
  logic             w_latLast;
  logic             w_stageLast;
  logic             w_outLast;
  logic [LOG2N-1:0] w_loadRev;
  logic [LOG2N-1:0] w_kExt;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_j;
  logic [LOG2N-1:0] w_a;
  logic [LOG2N-1:0] w_b;
  logic [SW:0]      w_stageP1;
  logic [SW:0]      w_twShift;
  logic [KW-1:0]    w_tw;

  assign w_loadLast  = (r_loadCnt == LOG2N'(N - 1));
  assign w_kLast     = (r_k == KW'(N / 2 - 1));
  assign w_latLast   = (r_latCnt == LW'(LAT - 1));
  assign w_stageLast = (r_stage == SW'(LOG2N - 1));
  assign w_outLast   = (r_outCnt == LOG2N'(N - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Abort overrides every transition; outputs depend only on registered state except o_load_en.
  always_comb begin
    w_nextState = r_state;
    o_ready_in  = 1'b0;
    o_load_en   = 1'b0;
    o_issue     = 1'b0;
    o_out_valid = 1'b0;
    o_busy      = (r_state != IDLE);
    if (i_abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_start) w_nextState = LOAD;
        LOAD:    if (i_valid_in && w_loadLast) w_nextState = ISSUE;
        ISSUE:   if (w_kLast) w_nextState = WAIT;
        WAIT:    if (w_latLast) w_nextState = w_stageLast ? OUTPUT : ISSUE;
        OUTPUT:  if (i_out_ready && w_outLast) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
    case (r_state)
      LOAD: begin
        o_ready_in = 1'b1;
        o_load_en  = i_valid_in;
      end
      ISSUE:   o_issue = 1'b1;
      OUTPUT:  o_out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loadCnt <= '0;
      r_stage   <= '0;
      r_k       <= '0;
      r_latCnt  <= '0;
      r_outCnt  <= '0;
    end else if (i_abort) begin
      r_loadCnt <= '0;
      r_stage   <= '0;
      r_k       <= '0;
      r_latCnt  <= '0;
      r_outCnt  <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (i_valid_in) r_loadCnt <= w_loadLast ? '0 : r_loadCnt + 1'b1;
        end
        ISSUE: begin
          r_k <= w_kLast ? '0 : r_k + 1'b1;
        end
        WAIT: begin
          if (w_latLast) begin
            r_latCnt <= '0;
            if (!w_stageLast) r_stage <= r_stage + 1'b1;
          end else begin
            r_latCnt <= r_latCnt + 1'b1;
          end
        end
        OUTPUT: begin
          if (i_out_ready) begin
            if (w_outLast) begin
              r_outCnt <= '0;
              r_stage  <= '0;
            end else begin
              r_outCnt <= r_outCnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= !i_abort && (r_state == OUTPUT) && i_out_ready && w_outLast;
    end
  end

  always_comb begin
    w_loadRev = '0;
    for (int i = 0; i < LOG2N; i++) begin
      w_loadRev[i] = r_loadCnt[LOG2N-1-i];
    end
  end

  // The stage+1 shift amount is one bit wider than the stage so the last stage cannot wrap.
  always_comb begin
    w_kExt    = LOG2N'(r_k);
    w_span    = LOG2N'(1) << r_stage;
    w_j       = w_kExt & (w_span - 1'b1);
    w_stageP1 = {1'b0, r_stage} + 1'b1;
    w_a       = ((w_kExt >> r_stage) << w_stageP1) | w_j;
    w_b       = w_a + w_span;
    w_twShift = (SW + 1)'(LOG2N - 1) - {1'b0, r_stage};
    w_tw      = KW'(w_j << w_twShift);
  end

  assign o_load_addr    = (BITREV_LOAD != 0) ? w_loadRev : r_loadCnt;
  assign o_stage_sel    = r_stage;
  assign o_k_idx        = r_k;
  assign o_addr_a       = o_issue ? w_a : '0;
  assign o_addr_b       = o_issue ? w_b : '0;
  assign o_twiddle_addr = o_issue ? w_tw : '0;
  assign o_out_addr     = r_outCnt;
  assign o_done         = r_done;

endmodule

// File: tb/tb_fft_control_n.sv
// tb_fft_control_n: randomized bench checking fft_control_n against a schedule model built from
// handshake counts and textbook DIT butterfly indexing. Instance B covers LOG2N=4, LAT=1, natural load.
`timescale 1ns/1ps
module tb_fft_control_n;
  localparam int AN = 8;
  localparam int ALOG = 3;
  localparam int ALAT = 6;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  int nCmp = 0;
  int nErr = 0;

  logic       aStart, aAbort, aValidIn, aOutReady;
  logic       aReadyIn, aLoadEn, aIssue, aOutValid, aBusy, aDone;
  logic [2:0] aLoadAddr, aAddrA, aAddrB, aOutAddr;
  logic [1:0] aStage, aK, aTw;

  logic       bStart, bAbort, bValidIn, bOutReady;
  logic       bReadyIn, bLoadEn, bIssue, bOutValid, bBusy, bDone;
  logic [3:0] bLoadAddr, bAddrA, bAddrB, bOutAddr;
  logic [1:0] bStage;
  logic [2:0] bK, bTw;

  fft_control_n #(.LOG2N(3), .LAT(6), .BITREV_LOAD(1)) dutA (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(aStart), .i_abort(aAbort),
    .i_valid_in(aValidIn), .o_ready_in(aReadyIn), .o_load_en(aLoadEn), .o_load_addr(aLoadAddr),
    .o_issue(aIssue), .o_stage_sel(aStage), .o_k_idx(aK), .o_addr_a(aAddrA), .o_addr_b(aAddrB),
    .o_twiddle_addr(aTw), .o_out_valid(aOutValid), .i_out_ready(aOutReady), .o_out_addr(aOutAddr),
    .o_busy(aBusy), .o_done(aDone)
  );

  fft_control_n #(.LOG2N(4), .LAT(1), .BITREV_LOAD(0)) dutB (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(bStart), .i_abort(bAbort),
    .i_valid_in(bValidIn), .o_ready_in(bReadyIn), .o_load_en(bLoadEn), .o_load_addr(bLoadAddr),
    .o_issue(bIssue), .o_stage_sel(bStage), .o_k_idx(bK), .o_addr_a(bAddrA), .o_addr_b(bAddrB),
    .o_twiddle_addr(bTw), .o_out_valid(bOutValid), .i_out_ready(bOutReady), .o_out_addr(bOutAddr),
    .o_busy(bBusy), .o_done(bDone)
  );

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if (v[i]) r |= 1 << (bits - 1 - i);
    return r;
  endfunction

  // One transform on instance A, checked every cycle. Cycle 0 is the cycle carrying i_start.
  task automatic run_a(input int vMode, input int rMode, input int abortCyc, input int rstCyc,
                       output int doneCyc);
    int loadCnt, lastLoad, outStart, outCnt, lastOut, rel, s, r, span, expA, expB, expTw;
    bit inLoad, inBfly, inOut, isDone, expIssue, finished;
    loadCnt = 0; lastLoad = -1; outStart = 1 << 30; outCnt = 0; lastOut = -1;
    finished = 0; doneCyc = -1;
    @(posedge i_clk); #1;
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      aStart = (cyc == 0) ? 1'b1 : ((lastOut < 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      aAbort = (cyc == abortCyc);
      case (vMode)
        0:       aValidIn = 1'b1;
        1:       aValidIn = (cyc % 2 == 0);
        default: aValidIn = 1'($urandom_range(0, 1));
      endcase
      case (rMode)
        0:       aOutReady = 1'b1;
        1:       aOutReady = (cyc % 3 == 0);
        default: aOutReady = 1'($urandom_range(0, 1));
      endcase
      #1;
      inLoad = (cyc >= 1) && (lastLoad < 0);
      inBfly = (lastLoad >= 0) && (cyc < outStart);
      inOut  = (cyc >= outStart) && (lastOut < 0);
      isDone = (lastOut >= 0);
      expIssue = 0; expA = 0; expB = 0; expTw = 0; s = 0; r = 0;
      if (inBfly) begin
        rel = cyc - lastLoad - 1;
        s = rel / (AN / 2 + ALAT);
        r = rel % (AN / 2 + ALAT);
        if (r < AN / 2) begin
          span = 1 << s;
          expIssue = 1;
          expA = (r / span) * 2 * span + (r % span);
          expB = expA + span;
          expTw = (r % span) * (AN / (2 * span));
        end
      end
      nCmp++; if (aBusy !== (inLoad || inBfly || inOut)) begin nErr++;
        $display("[TB] FAIL busy cyc=%0d got=%b exp=%b", cyc, aBusy, inLoad || inBfly || inOut); end
      nCmp++; if (aReadyIn !== inLoad) begin nErr++;
        $display("[TB] FAIL ready_in cyc=%0d got=%b exp=%b", cyc, aReadyIn, inLoad); end
      nCmp++; if (aLoadEn !== (inLoad && aValidIn)) begin nErr++;
        $display("[TB] FAIL load_en cyc=%0d got=%b exp=%b", cyc, aLoadEn, inLoad && aValidIn); end
      if (inLoad) begin
        nCmp++; if (aLoadAddr !== 3'(brev(loadCnt, ALOG))) begin nErr++;
          $display("[TB] FAIL load_addr cyc=%0d got=%0d exp=%0d", cyc, aLoadAddr, brev(loadCnt, ALOG)); end
      end
      nCmp++; if (aIssue !== expIssue) begin nErr++;
        $display("[TB] FAIL issue cyc=%0d got=%b exp=%b", cyc, aIssue, expIssue); end
      nCmp++; if ({aAddrA, aAddrB, aTw} !== {3'(expA), 3'(expB), 2'(expTw)}) begin nErr++;
        $display("[TB] FAIL bfly_addr cyc=%0d got a=%0d b=%0d tw=%0d exp a=%0d b=%0d tw=%0d",
                 cyc, aAddrA, aAddrB, aTw, expA, expB, expTw); end
      if (inBfly) begin
        nCmp++; if (aStage !== 2'(s)) begin nErr++;
          $display("[TB] FAIL stage cyc=%0d got=%0d exp=%0d", cyc, aStage, s); end
      end
      if (expIssue) begin
        nCmp++; if (aK !== 2'(r)) begin nErr++;
          $display("[TB] FAIL k_idx cyc=%0d got=%0d exp=%0d", cyc, aK, r); end
      end
      nCmp++; if (aOutValid !== inOut) begin nErr++;
        $display("[TB] FAIL out_valid cyc=%0d got=%b exp=%b", cyc, aOutValid, inOut); end
      if (inOut) begin
        nCmp++; if (aOutAddr !== 3'(outCnt)) begin nErr++;
          $display("[TB] FAIL out_addr cyc=%0d got=%0d exp=%0d", cyc, aOutAddr, outCnt); end
      end
      nCmp++; if (aDone !== isDone) begin nErr++;
        $display("[TB] FAIL done cyc=%0d got=%b exp=%b", cyc, aDone, isDone); end
      if (aDone === 1'b1 && doneCyc < 0) doneCyc = cyc;

      if (inLoad && aValidIn) begin
        loadCnt++;
        if (loadCnt == AN) begin
          lastLoad = cyc;
          outStart = cyc + 1 + ALOG * (AN / 2 + ALAT);
        end
      end
      if (inOut && aOutReady) begin
        outCnt++;
        if (outCnt == AN) lastOut = cyc;
      end
      if (isDone) finished = 1;

      if (cyc == abortCyc) begin
        @(posedge i_clk); #1;
        aAbort = 0; aStart = 0; aValidIn = 1; aOutReady = 1;
        #1;
        nCmp++; if ({aBusy, aIssue, aLoadEn, aOutValid, aDone} !== 5'b0) begin nErr++;
          $display("[TB] FAIL abort_drop got busy/issue/load_en/out_valid/done=%b exp=00000",
                   {aBusy, aIssue, aLoadEn, aOutValid, aDone}); end
        repeat (4) begin
          @(posedge i_clk); #2;
          nCmp++; if ({aBusy, aDone} !== 2'b0) begin nErr++;
            $display("[TB] FAIL abort_idle got busy/done=%b exp=00", {aBusy, aDone}); end
        end
        return;
      end

      if (cyc == rstCyc) begin
        #1; i_rst_n = 0; aStart = 1;
        #1;
        nCmp++; if ({aReadyIn, aLoadEn, aLoadAddr, aIssue, aStage, aK, aAddrA, aAddrB, aTw,
                     aOutValid, aOutAddr, aBusy, aDone} !== '0) begin nErr++;
          $display("[TB] FAIL rst_async outputs=%h exp=0", {aReadyIn, aLoadEn, aLoadAddr, aIssue,
                   aStage, aK, aAddrA, aAddrB, aTw, aOutValid, aOutAddr, aBusy, aDone}); end
        repeat (3) begin
          @(posedge i_clk); #2;
          nCmp++; if ({aBusy, aOutValid, aOutAddr, aDone} !== '0) begin nErr++;
            $display("[TB] FAIL rst_hold busy/out_valid/out_addr/done=%h exp=0",
                     {aBusy, aOutValid, aOutAddr, aDone}); end
        end
        aStart = 0;
        #2; i_rst_n = 1;
        @(posedge i_clk); #2;
        nCmp++; if (aBusy !== 1'b0) begin nErr++;
          $display("[TB] FAIL rst_release busy got=%b exp=0", aBusy); end
        return;
      end

      @(posedge i_clk); #1;
    end
    aStart = 0; aValidIn = 0;
    nCmp++; if (!finished) begin nErr++;
      $display("[TB] FAIL timeout transform did not complete got=running exp=done"); end
  endtask

  task automatic test_reset();
    aValidIn = 1; aStart = 1; bValidIn = 1; bStart = 1;
    repeat (3) @(posedge i_clk);
    #2;
    nCmp++; if ({aReadyIn, aLoadEn, aLoadAddr, aIssue, aStage, aK, aAddrA, aAddrB, aTw,
                 aOutValid, aOutAddr, aBusy, aDone} !== '0) begin nErr++;
      $display("[TB] FAIL reset_a outputs=%h exp=0", {aReadyIn, aLoadEn, aLoadAddr, aIssue,
               aStage, aK, aAddrA, aAddrB, aTw, aOutValid, aOutAddr, aBusy, aDone}); end
    nCmp++; if ({bReadyIn, bLoadEn, bLoadAddr, bIssue, bStage, bK, bAddrA, bAddrB, bTw,
                 bOutValid, bOutAddr, bBusy, bDone} !== '0) begin nErr++;
      $display("[TB] FAIL reset_b outputs=%h exp=0", {bReadyIn, bLoadEn, bLoadAddr, bIssue,
               bStage, bK, bAddrA, bAddrB, bTw, bOutValid, bOutAddr, bBusy, bDone}); end
    aStart = 0; aValidIn = 0; bStart = 0; bValidIn = 0;
    @(negedge i_clk); i_rst_n = 1;
    @(posedge i_clk); #2;
    nCmp++; if ({aBusy, bBusy} !== 2'b00) begin nErr++;
      $display("[TB] FAIL reset_release busy got=%b exp=00", {aBusy, bBusy}); end
  endtask

  task automatic test_nominal();
    int d;
    run_a(0, 0, -1, -1, d);
    nCmp++; if (d !== 47) begin nErr++;
      $display("[TB] FAIL nominal_done_cycle got=%0d exp=47", d); end
  endtask

  task automatic test_stalls();
    int d;
    run_a(1, 0, -1, -1, d);
    nCmp++; if (d !== 55) begin nErr++;
      $display("[TB] FAIL stall_done_cycle got=%0d exp=55", d); end
  endtask

  task automatic test_backpressure();
    int d;
    run_a(0, 1, -1, -1, d);
    nCmp++; if (d !== 61) begin nErr++;
      $display("[TB] FAIL backpressure_done_cycle got=%0d exp=61", d); end
  endtask

  // Cycle 25 falls in the stage-1 latency window of a stall-free run.
  task automatic test_abort();
    int d;
    run_a(0, 0, 25, -1, d);
    run_a(0, 0, -1, -1, d);
    nCmp++; if (d !== 47) begin nErr++;
      $display("[TB] FAIL post_abort_done_cycle got=%0d exp=47", d); end
  endtask

  task automatic test_start_abort_idle();
    int d;
    run_a(0, 0, 0, -1, d);
  endtask

  task automatic test_reset_mid_output();
    int d;
    run_a(0, 0, -1, 42, d);
  endtask

  task automatic test_random();
    int d;
    for (int t = 0; t < 4; t++) run_a(2, 2, -1, -1, d);
  endtask

  // 70 cycles total; counting the start cycle as 0 puts o_done at cycle 69.
  task automatic test_param_sweep();
    int loads[$];
    int tw3[$];
    int tw2[$];
    int doneAt;
    doneAt = -1;
    @(posedge i_clk); #1;
    bStart = 1; bValidIn = 1; bOutReady = 1; bAbort = 0;
    for (int cyc = 0; cyc < 300 && doneAt < 0; cyc++) begin
      #1;
      if (bLoadEn === 1'b1) loads.push_back(int'(bLoadAddr));
      if (bIssue === 1'b1 && bStage === 2'd3) tw3.push_back(int'(bTw));
      if (bIssue === 1'b1 && bStage === 2'd2) tw2.push_back(int'(bTw));
      if (bDone === 1'b1) doneAt = cyc;
      @(posedge i_clk); #1;
      bStart = 0;
    end
    nCmp++; if (loads.size() != 16) begin nErr++;
      $display("[TB] FAIL sweep_load_count got=%0d exp=16", loads.size()); end
    foreach (loads[i]) begin
      nCmp++; if (loads[i] != i) begin nErr++;
        $display("[TB] FAIL sweep_load_addr[%0d] got=%0d exp=%0d", i, loads[i], i); end
    end
    nCmp++; if (tw3.size() != 8 || tw2.size() != 8) begin nErr++;
      $display("[TB] FAIL sweep_issue_count got=%0d/%0d exp=8/8", tw3.size(), tw2.size()); end
    foreach (tw3[i]) begin
      nCmp++; if (tw3[i] != i) begin nErr++;
        $display("[TB] FAIL sweep_tw_s3[%0d] got=%0d exp=%0d", i, tw3[i], i); end
    end
    foreach (tw2[i]) begin
      nCmp++; if (tw2[i] != (i % 4) * 2) begin nErr++;
        $display("[TB] FAIL sweep_tw_s2[%0d] got=%0d exp=%0d", i, tw2[i], (i % 4) * 2); end
    end
    nCmp++; if (doneAt != 69) begin nErr++;
      $display("[TB] FAIL sweep_done_cycle got=%0d exp=69", doneAt); end
  endtask

  initial begin
    aStart = 0; aAbort = 0; aValidIn = 0; aOutReady = 0;
    bStart = 0; bAbort = 0; bValidIn = 0; bOutReady = 0;
    test_reset();
    test_nominal();
    test_stalls();
    test_backpressure();
    test_abort();
    test_start_abort_idle();
    test_reset_mid_output();
    test_random();
    test_param_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
